// File: rtl/yarvi_pkg.sv
// yarvi_pkg: shared constants and types for the yarvi SoC transmit path
package yarvi_pkg;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/yarvi_rr_pick.sv
// yarvi_rr_pick: round-robin pick of the first set request after last, with wrap
module yarvi_rr_pick #(
  parameter int N = 2,
  localparam int GW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          any,
  output logic [GW-1:0] pick
);
  assign any = |req;
  // walk offsets from farthest to nearest so the nearest set bit after last wins
  always_comb begin
    pick = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) pick = GW'((int'(last) + i) % N);
  end
endmodule

// File: rtl/yarvi_tx_arbiter.sv
// yarvi_tx_arbiter: line-granular round-robin sharing of the SoC transmit byte stream
module yarvi_tx_arbiter
  import yarvi_pkg::*;
#(
  parameter int N = 2,
  parameter int IDLE_MAX = 255,
  localparam int GW = (N > 2) ? $clog2(N) : 1,
  localparam int CW = $clog2(IDLE_MAX + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [GW-1:0]  grant_id,
  output logic           locked
);
  arb_state_t state;
  logic [GW-1:0] last;
  logic [GW-1:0] pick;
  logic [CW-1:0] idle_cnt;
  logic any;
  logic free;
  logic accept;
  logic [7:0] byte_in;
  yarvi_rr_pick #(.N(N)) u_pick (
    .req(req_valid),
    .last(last),
    .any(any),
    .pick(pick)
  );
  assign locked = state == ARB_LOCKED;
  assign free = !tx_valid || tx_ready;
  assign req_ready = (locked && free) ? N'(1) << grant_id : '0;
  assign accept = locked && free && req_valid[grant_id];
  assign byte_in = req_data[8*grant_id +: 8];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      last <= GW'(N - 1);
      grant_id <= '0;
      idle_cnt <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      if (accept) begin
        tx_valid <= 1'b1;
        tx_data <= byte_in;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (!locked) begin
        idle_cnt <= '0;
        if (any) begin
          state <= ARB_LOCKED;
          grant_id <= pick;
        end
      end else if (accept) begin
        idle_cnt <= '0;
        if (byte_in == ASCII_LF) begin
          state <= ARB_IDLE;
          last <= grant_id;
        end
      end else if (!req_valid[grant_id]) begin
        // a stalled owner that still holds valid is not idle; only absent valid counts
        idle_cnt <= (idle_cnt == CW'(IDLE_MAX)) ? idle_cnt : idle_cnt + 1'b1;
        if (idle_cnt == CW'(IDLE_MAX - 1)) begin
          state <= ARB_IDLE;
          last <= grant_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_yarvi_tx_arbiter.sv
// tb_yarvi_tx_arbiter: queue-driven requesters, output scoreboard and arbitration vector table
module tb_yarvi_tx_arbiter;
  localparam int N = 3;
  localparam int IDLE_MAX = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready = 1'b1;
  logic [1:0] grant_id;
  logic locked;
  logic [7:0] rq [N][$];
  logic [7:0] exp_q [$];
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [N-1:0] mask;
    logic [1:0] win;
  } vec_t;
  vec_t vecs [9];
  logic [8:0] rr_seq [8];

  always #5 clock = ~clock;

  yarvi_tx_arbiter #(.N(N), .IDLE_MAX(IDLE_MAX)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant_id(grant_id),
    .locked(locked)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rq[i].size() > 0;
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  // handshakes are sampled mid-cycle, inputs change just after the rising edge
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clock);
    acc = reset ? '0 : req_valid & req_ready;
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_extra: got %0h expected no byte", tx_data);
      end else begin
        chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic wait_lock(input logic want, input string nm);
    for (int k = 0; k < 20 && locked !== want; k++) tick();
    chk(nm, 32'(locked), 32'(want));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs = '{'{3'b011, 2'd0}, '{3'b011, 2'd1}, '{3'b111, 2'd2},
             '{3'b110, 2'd1}, '{3'b101, 2'd2}, '{3'b100, 2'd2},
             '{3'b011, 2'd0}, '{3'b100, 2'd2}, '{3'b010, 2'd1}};
    rr_seq = '{9'h000, 9'h141, 9'h142, 9'h10A, 9'h000, 9'h141, 9'h142, 9'h10A};
    drive();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    // single line, latency and unlock after newline
    rq[0] = '{8'h68, 8'h69, 8'h0A};
    exp_q = '{8'h68, 8'h69, 8'h0A};
    drive();
    tick();
    chk("hi_lock", 32'(locked), 1);
    chk("hi_latency", 32'(tx_valid), 0);
    tick();
    chk("hi_first", 32'({tx_valid, tx_data}), 32'h168);
    tick();
    chk("hi_second", 32'(tx_data), 32'h69);
    tick();
    chk("hi_third", 32'(tx_data), 32'h0A);
    chk("hi_unlock", 32'(locked), 0);
    tick();
    tick();
    chk("hi_drain", 32'(tx_valid), 0);
    // two requesters contend: whole line each, one bubble between
    do_reset();
    rq[0] = '{8'h41, 8'h42, 8'h0A};
    rq[1] = '{8'h41, 8'h42, 8'h0A};
    exp_q = '{8'h41, 8'h42, 8'h0A, 8'h41, 8'h42, 8'h0A};
    drive();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_out%0d", k), 32'({tx_valid, tx_valid ? tx_data : 8'h00}), 32'(rr_seq[k]));
      if (k == 4) chk("rr_grant1", 32'(grant_id), 1);
    end
    wait_lock(1'b0, "rr_unlock");
    tick();
    tick();
    // arbitration table, continuing from last = 1
    foreach (vecs[v]) begin
      for (int i = 0; i < N; i++)
        if (vecs[v].mask[i]) rq[i] = '{8'(8'h30 + i), 8'h0A};
      exp_q.push_back(8'(8'h30 + vecs[v].win));
      exp_q.push_back(8'h0A);
      drive();
      wait_lock(1'b1, $sformatf("tbl_lock%0d", v));
      chk($sformatf("tbl_grant%0d", v), 32'(grant_id), 32'(vecs[v].win));
      wait_lock(1'b0, $sformatf("tbl_unlock%0d", v));
      for (int i = 0; i < N; i++) rq[i].delete();
      drive();
      tick();
      tick();
    end
    // downstream stall longer than IDLE_MAX with valid held high
    rq[0] = '{8'h41, 8'h42, 8'h43, 8'h0A};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h0A};
    drive();
    wait_lock(1'b1, "st_lock");
    tick();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("st_data", 32'({tx_valid, tx_data}), 32'h141);
      chk("st_ready", 32'(req_ready), 0);
      chk("st_locked", 32'(locked), 1);
    end
    tx_ready = 1'b1;
    wait_lock(1'b0, "st_done");
    tick();
    tick();
    // owner goes quiet mid-line: timeout hands over to requester 1
    do_reset();
    rq[0] = '{8'h41};
    rq[1] = '{8'h51, 8'h0A};
    exp_q = '{8'h41, 8'h51, 8'h0A};
    drive();
    tick();
    chk("to_grant0", 32'({locked, grant_id}), 32'h4);
    tick();
    chk("to_accept", 32'({tx_valid, tx_data}), 32'h141);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("to_lock%0d", k), 32'(locked), (k == 4) ? 0 : 1);
    end
    chk("to_grant1", 32'(grant_id), 1);
    wait_lock(1'b0, "to_done");
    tick();
    tick();
    // reset while a byte is stuck in the output register
    rq[1] = '{8'h41};
    drive();
    wait_lock(1'b1, "rm_lock");
    chk("rm_owner", 32'(grant_id), 1);
    tx_ready = 1'b0;
    tick();
    chk("rm_pending", 32'(tx_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_valid", 32'(tx_valid), 0);
    chk("rm_locked", 32'(locked), 0);
    chk("rm_grant", 32'(grant_id), 0);
    tx_ready = 1'b1;
    repeat (4) tick();
    chk("rm_quiet", 32'(tx_valid), 0);
    // three requesters, nine lines, grants rotate
    do_reset();
    for (int i = 0; i < N; i++) rq[i] = '{8'h78, 8'h0A, 8'h78, 8'h0A, 8'h78, 8'h0A};
    repeat (9) begin
      exp_q.push_back(8'h78);
      exp_q.push_back(8'h0A);
    end
    drive();
    for (int l = 0; l < 9; l++) begin
      wait_lock(1'b1, $sformatf("rot_lock%0d", l));
      chk($sformatf("rot_grant%0d", l), 32'(grant_id), 32'(l % 3));
      wait_lock(1'b0, $sformatf("rot_unlock%0d", l));
    end
    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    chk("rq_empty", rq[0].size() + rq[1].size() + rq[2].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/yarvi_tx_arbiter.md
# yarvi_tx_arbiter

Shares the single `yarvi_soc` transmit byte stream between N byte-stream requesters, such as the core console, a debug monitor and a boot loader echo. Arbitration is round-robin and line-granular: a granted requester keeps the channel until it sends a newline or goes idle, so console lines never interleave. One registered output stage drives the SoC-side `tx_valid`/`tx_data`/`tx_ready` handshake.

## Interface
- `N`, default 2: number of requesters, 2..8.
- `IDLE_MAX`, default 255: cycles without `req_valid` from the granted requester before its lock is revoked; must be at least 1.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, N: per-requester byte valid.
- `req_data`, in, 8*N: requester i's byte is bits [8i+7:8i].
- `req_ready`, out, N: per-requester accept; at most one bit is high.
- `tx_valid`, out, 1: output byte valid (registered).
- `tx_data`, out, 8: output byte (registered).
- `tx_ready`, in, 1: downstream accept.
- `grant_id`, out, $clog2(N) (minimum 1): index of the current or last owner.
- `locked`, out, 1: high while in LOCKED.

## Operation
- Transfer rules:
  - A transfer on either side occurs when valid and ready are both high on a rising edge.
  - Valid never waits on ready.
  - Once `tx_valid` is high, `tx_valid` and `tx_data` hold until `tx_ready`.
- States are IDLE and LOCKED.
- IDLE:
  - `req_ready` = 0.
  - If any `req_valid` bit is high, pick the first set bit searching from `(last+1) mod N` upward with wrap.
  - Register the pick into `grant_id`, then go to LOCKED.
  - If no bit is set, stay in IDLE.
- LOCKED, with owner g = `grant_id`:
  - `req_ready[g] = !tx_valid || tx_ready`. All other `req_ready` bits are 0.
  - On an accepted byte, load `tx_data` and set `tx_valid`.
  - When `tx_ready` is high and nothing is accepted, clear `tx_valid`.
  - Accepting byte 8'h0A: go to IDLE and set `last` = g.
  - Idle counter:
    - Cleared on entry to LOCKED and on every accepted byte.
    - Increments each cycle `req_valid[g]` is 0.
    - Cycles stalled by `tx_ready` = 0 with `req_valid[g]` = 1 do not count.
    - Saturates; its width is $clog2(IDLE_MAX+1).
  - When the counter reaches IDLE_MAX: go to IDLE, set `last` = g. No byte is lost.
- A byte still pending in the output register when the state returns to IDLE drains normally. A new owner's first byte waits for the register to free.
- Requesters with `req_valid` low are skipped. A requester that drops valid mid-line keeps the lock until the newline or the timeout.
- Reset values:
  - State IDLE, `last` = N-1 (so requester 0 wins first), `grant_id` = 0.
  - `locked` = 0, `tx_valid` = 0, `tx_data` = 0, `req_ready` = 0, counter = 0.
- Reset mid-operation: any pending output byte is discarded and `tx_valid` is low from the following cycle. Requesters must re-present their bytes.

## Timing
- Latency: a byte accepted at edge t appears on `tx_valid`/`tx_data` from t+1.
- Throughput: 1 byte per cycle per owner while `tx_ready` = 1.
- Arbitration:
  - `req_valid` sampled in IDLE at edge t gives LOCKED at t+1.
  - `req_ready` can be high in the cycle after edge t; the first accept is at edge t+1.
- Newline accepted at edge t:
  - IDLE during the cycle after t.
  - Next owner is granted at edge t+1.
  - Next owner's first accept is at edge t+2 at the earliest. Handover costs exactly one bubble cycle.
- Timeout: with the counter cleared at edge t0 and `req_valid[g]` low from then on, the state is IDLE after edge t0+IDLE_MAX.
- `req_ready` is combinational from registered state and `tx_ready` only. There is no path from `req_valid` to `req_ready`.

## Structure
- Shared package `yarvi_pkg` holds `ASCII_LF = 8'h0A` and the state enum `arb_state_t {ARB_IDLE, ARB_LOCKED}`.
- One sub-module, `yarvi_rr_pick`:
  - Parameter N; inputs `req[N]`, `last`; outputs `any`, `pick`.
  - Purely combinational rotate-and-priority-encode.
- The top holds the state, `grant_id`, `last`, the idle counter and the output register.

## Test plan
- After reset, requester 0 sends "hi\n" while requester 1 is idle: `tx_data` is 68,69,0A on three consecutive cycles, the first `tx_valid` is 2 cycles after `req_valid` rises, and `locked` falls after 0A.
- Requesters 0 and 1 each hold "AB\n" valid from the same cycle: output is 41,42,0A from requester 0, one bubble, then 41,42,0A from requester 1. The next contention is won by requester 0.
- `tx_ready` is held low for 10 cycles mid-line with the owner's `req_valid` high: `tx_data` stays stable, `req_ready` stays 0, there is no timeout, and all bytes arrive in order.
- With IDLE_MAX = 4, requester 0 sends 41 and drops valid while requester 1 waits: requester 1 is granted exactly 4 cycles after 41 is accepted plus one, and its bytes follow 41.
- Assert `reset` for one cycle while 41 is pending with `tx_ready` low: the next cycle has `tx_valid` = 0, `locked` = 0, `grant_id` = 0, and 41 never appears after reset.
- With N = 3, all three requesters assert "x\n" repeatedly for 9 lines: grants rotate 0,1,2,0,1,2,… and no byte is lost or duplicated, checked against a scoreboard.
